stream_mux_rr: RTL and testbench

Parametrised N-channel, WIDTH-bit stream multiplexer with a valid/ready handshake on every input and on the output. It generalises the fixed 8-bit 4:1 select into a registered selector with two modes: fixed select, driven by `sel`, and fair round-robin arbitration. It sits between several producer channels and one consumer, and delivers one word per cycle at full throughput.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/stream_mux_rr_rr_arbiter.sv | 38 +++
 rtl/stream_mux_rr.sv | 108 ++++++++++
 tb/tb_stream_mux_rr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Round-robin pointer advance: the channel after the winner, wrapping at n-1.
  function automatic int unsigned ptr_next(input int unsigned gnt, input int unsigned n);
    return (gnt == n - 1) ? 0 : gnt + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_rr_arbiter.sv
// Combinational round-robin arbiter: masked priority search starting at ptr.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt,
  output logic            gnt_v
);

  logic [SELW-1:0] hi_gnt;
  logic [SELW-1:0] lo_gnt;
  logic            hi_v;
  logic            lo_v;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_gnt = '0;
    lo_gnt = '0;
    hi_v   = 1'b0;
    lo_v   = 1'b0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_v   = 1'b1;
        lo_gnt = SELW'(i);
        if (i >= int'(ptr)) begin
          hi_v   = 1'b1;
          hi_gnt = SELW'(i);
        end
      end
    end
    gnt_v = lo_v;
    gnt   = hi_v ? hi_gnt : lo_gnt;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select and round-robin modes.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 4,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] in_data [N],
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  mux_mode_t       mode_e;
  logic            fix_v;
  logic [SELW-1:0] rr_gnt;
  logic            rr_gnt_v;
  logic [SELW-1:0] gnt;
  logic            gnt_v;
  logic            load;
  logic [WIDTH-1:0] gnt_data;

  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic [SELW-1:0]  out_chan_d, out_chan_q;
  logic             out_valid_d, out_valid_q;
  logic [SELW-1:0]  ptr_d, ptr_q;

  assign mode_e = mux_mode_t'(mode);

  // Fixed-mode valid; a sel outside 0..N-1 matches no channel and so never grants.
  always_comb begin
    fix_v = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SELW'(i)) fix_v = in_valid[i];
    end
  end

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr_q),
    .gnt   (rr_gnt),
    .gnt_v (rr_gnt_v)
  );

  // Mode mux and handshake: only the granted channel sees ready, and only when loading.
  always_comb begin
    gnt      = (mode_e == MODE_RR) ? rr_gnt : sel;
    gnt_v    = (mode_e == MODE_RR) ? rr_gnt_v : fix_v;
    load     = !out_valid_q || out_ready;
    in_ready = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) begin
        in_ready[i] = load && gnt_v;
        gnt_data    = in_data[i];
      end
    end
  end

  // Output register and pointer next state; everything holds while stalled.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_v) begin
        out_data_d  = gnt_data;
        out_chan_d  = gnt;
        out_valid_d = 1'b1;
        if (mode_e == MODE_RR) ptr_d = SELW'(ptr_next(32'(gnt), N));
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: N=4, WIDTH=8
  logic       a_mode;
  logic [1:0] a_sel;
  logic [7:0] a_data [4];
  logic [3:0] a_valid;
  logic [3:0] a_in_ready;
  logic [7:0] a_out_data;
  logic [1:0] a_out_chan;
  logic       a_out_valid;
  logic       a_out_ready;

  stream_mux_rr #(
    .WIDTH (8),
    .N     (4)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (a_mode),
    .sel       (a_sel),
    .in_data   (a_data),
    .in_valid  (a_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_chan  (a_out_chan),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  // DUT B: N=3, WIDTH=16 (non-power-of-2 channel count)
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [15:0] b_data [3];
  logic [2:0]  b_valid;
  logic [2:0]  b_in_ready;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_chan;
  logic        b_out_valid;
  logic        b_out_ready;

  stream_mux_rr #(
    .WIDTH (16),
    .N     (3)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (b_mode),
    .sel       (b_sel),
    .in_data   (b_data),
    .in_valid  (b_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_chan  (b_out_chan),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of DUT A
  int         m_ptr;
  bit         m_ov;
  logic [7:0] m_od;
  int         m_oc;
  logic [3:0] last_rdy;

  // One cycle on DUT A: drive, check handshake, clock, check registered outputs.
  task automatic step_a(input logic md, input logic [1:0] s, input logic [3:0] v,
                        input logic ordy);
    bit         load;
    bit         gv;
    int         g;
    logic [3:0] exp_rdy;
    a_mode      = md;
    a_sel       = s;
    a_valid     = v;
    a_out_ready = ordy;
    #1;
    load = !m_ov || ordy;
    gv   = 1'b0;
    g    = 0;
    if (md) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!gv && v[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end else begin
      g  = int'(s);
      gv = v[g];
    end
    exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0000;
    last_rdy = a_in_ready;
    check_eq("in_ready", 32'(a_in_ready), 32'(exp_rdy));
    if (load) begin
      if (gv) begin
        m_od = a_data[g];
        m_oc = g;
        m_ov = 1'b1;
        if (md) m_ptr = (g + 1) % 4;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(a_out_valid), 32'(m_ov));
    check_eq("out_data", 32'(a_out_data), 32'(m_od));
    check_eq("out_chan", 32'(a_out_chan), 32'(m_oc));
    check_eq("ptr", 32'(dut_a.ptr_q), 32'(m_ptr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held;
    int         exp_rr [5];
    int         exp_sw [3];
    exp_rr = '{0, 1, 2, 3, 0};
    exp_sw = '{3, 0, 3};

    // Reset with all inputs valid
    rst_n       = 1'b0;
    a_mode      = 1'b0;
    a_sel       = 2'd0;
    a_valid     = 4'hF;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) a_data[i] = 8'(8'hA0 + i);
    b_mode      = 1'b0;
    b_sel       = 2'd0;
    b_valid     = 3'b111;
    b_out_ready = 1'b1;
    b_data[0]   = 16'hBEEF;
    b_data[1]   = 16'h1234;
    b_data[2]   = 16'h5678;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_out_data", 32'(a_out_data), 32'd0);
    check_eq("rst_out_chan", 32'(a_out_chan), 32'd0);
    check_eq("rst_ptr", 32'(dut_a.ptr_q), 32'd0);
    check_eq("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_oc  = 0;

    // FIXED select
    a_data[0] = 8'h11;
    a_data[1] = 8'h22;
    a_data[2] = 8'h33;
    a_data[3] = 8'h44;
    step_a(1'b0, 2'd2, 4'hF, 1'b1);
    check_eq("fixed_rdy", 32'(last_rdy), 32'h4);
    check_eq("fixed_data", 32'(a_out_data), 32'h33);
    check_eq("fixed_chan", 32'(a_out_chan), 32'd2);

    // RR fairness, one word per cycle
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 2'd0, 4'hF, 1'b1);
      check_eq("rr_chan", 32'(a_out_chan), 32'(exp_rr[i]));
      check_eq("rr_valid", 32'(a_out_valid), 32'd1);
    end

    // RR skip and wrap from ptr=1
    check_eq("sw_ptr", 32'(dut_a.ptr_q), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b1, 2'd0, 4'b1001, 1'b1);
      check_eq("sw_chan", 32'(a_out_chan), 32'(exp_sw[i]));
    end

    // Backpressure: held word, no ready, then same-cycle drain+refill
    held = a_out_data;
    for (int i = 0; i < 3; i++) begin
      step_a(1'b1, 2'd0, 4'hF, 1'b0);
      check_eq("bp_rdy", 32'(last_rdy), 32'd0);
      check_eq("bp_data", 32'(a_out_data), 32'(held));
      check_eq("bp_valid", 32'(a_out_valid), 32'd1);
    end
    step_a(1'b1, 2'd0, 4'hF, 1'b1);
    check_eq("bp_release_rdy", 32'(last_rdy), 32'h1);
    check_eq("bp_release_data", 32'(a_out_data), 32'h11);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) a_data[i] = 8'($urandom);
      step_a(1'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(3, 0) != 0));
    end

    // N=3 block: sel=0 transfers, sel=3 never grants
    b_sel = 2'd0;
    @(posedge clk);
    #1;
    check_eq("n3_valid", 32'(b_out_valid), 32'd1);
    check_eq("n3_data", 32'(b_out_data), 32'hBEEF);
    b_sel = 2'd3;
    #1;
    check_eq("n3_sel3_rdy", 32'(b_in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("n3_sel3_valid", 32'(b_out_valid), 32'd0);
    check_eq("n3_sel3_hold", 32'(b_out_data), 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
